// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and the R/W bit encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR,
        WR_ACK,
        RD,
        RD_ACK,
        IGNORE
    } i2c_state_e;

    localparam logic I2C_RD_BIT = 1'b1;

endpackage

// File: rtl/i2c_in_filter.sv
// Pad input conditioner: 2-FF synchroniser, FILTER_LEN-clk stability filter, edge pulses.
// Latency: 2 + FILTER_LEN clk from pad to level; edge pulses are combinational on the level.
// Backpressure: none.
module i2c_in_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync_q;
    logic          lvl_q;
    logic          lvl_prev_q;
    logic [CW-1:0] cnt_q;

    // A new level is adopted only after FILTER_LEN consecutive clk cycles of disagreement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= 2'b11;
            lvl_q      <= 1'b1;
            lvl_prev_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            sync_q     <= {sync_q[0], pin_i};
            lvl_prev_q <= lvl_q;
            if (sync_q[1] == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                lvl_q <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign lvl_o  = lvl_q;
    assign rise_o = lvl_q & ~lvl_prev_q;
    assign fall_o = ~lvl_q & lvl_prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing NUM_REGS 8-bit registers at DEV_ADDR using an address/pointer/data protocol.
// Latency: 2+FILTER_LEN clk input filtering; SDA drive changes 1 clk after the filtered SCL fall.
// Backpressure: none; SCL is never stretched and host writes are accepted every clk.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h42,
    parameter int         NUM_REGS   = 16,
    parameter int         FILTER_LEN = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sda_in,
    input  logic                        scl_in,
    output logic                        sda_oe,
    output logic                        scl_oe,
    input  logic                        host_wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] host_wr_addr,
    input  logic [7:0]                  host_wr_data,
    output logic [NUM_REGS*8-1:0]       regs_flat,
    output logic                        i2c_wr_valid,
    output logic [$clog2(NUM_REGS)-1:0] i2c_wr_addr,
    output logic [7:0]                  i2c_wr_data,
    output logic                        busy
);

    localparam int AW = $clog2(NUM_REGS);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(clk), .reset_n(reset_n), .pin_i(scl_in),
        .lvl_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(clk), .reset_n(reset_n), .pin_i(sda_in),
        .lvl_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    i2c_state_e    state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          oe_q, oe_d;
    logic          rw_q, rw_d;
    logic          i2c_commit;
    logic [7:0]    rd_byte;
    logic [7:0]    regs_q [NUM_REGS];
    logic          wr_vld_q;
    logic [AW-1:0] wr_addr_q;
    logic [7:0]    wr_data_q;

    logic start_c, stop_c;
    assign start_c = sda_fall & scl_lvl;
    assign stop_c  = sda_rise & scl_lvl;
    assign rd_byte = regs_q[ptr_q];

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        oe_d       = oe_q;
        rw_d       = rw_q;
        i2c_commit = 1'b0;
        if (start_c) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
        end else if (stop_c) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WR: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (state_q == ADDR) begin
                            if (shift_q[7:1] == DEV_ADDR) begin
                                oe_d    = 1'b1;
                                rw_d    = shift_q[0];
                                state_d = ADDR_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end else if (state_q == PTR) begin
                            ptr_d   = shift_q[AW-1:0];
                            oe_d    = 1'b1;
                            state_d = PTR_ACK;
                        end else begin
                            // Commit uses the pre-increment pointer; see the register bank.
                            i2c_commit = 1'b1;
                            oe_d       = 1'b1;
                            ptr_d      = ptr_q + 1'b1;
                            state_d    = WR_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q == I2C_RD_BIT) begin
                            oe_d      = ~rd_byte[7];
                            shift_d   = {rd_byte[6:0], 1'b0};
                            bit_cnt_d = 4'd1;
                            state_d   = RD;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = PTR;
                        end
                    end
                end
                PTR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        state_d = WR;
                    end
                end
                RD: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            oe_d      = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = RD_ACK;
                        end else begin
                            oe_d      = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    // bit_cnt_q == 1 here marks an ACK seen on the preceding SCL rise.
                    if (scl_rise) begin
                        if (sda_lvl) begin
                            state_d = IGNORE;
                        end else begin
                            ptr_d     = ptr_q + 1'b1;
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        oe_d    = ~rd_byte[7];
                        shift_d = {rd_byte[6:0], 1'b0};
                        state_d = RD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            oe_q      <= 1'b0;
            rw_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            oe_q      <= oe_d;
            rw_q      <= rw_d;
        end
    end

    // Host write is applied last so it wins over a same-clk I2C commit to the same index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_vld_q <= i2c_commit;
            if (i2c_commit) begin
                regs_q[ptr_q] <= shift_q;
                wr_addr_q     <= ptr_q;
                wr_data_q     <= shift_q;
            end
            if (host_wr_en) regs_q[host_wr_addr] <= host_wr_data;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*8 +: 8] = regs_q[g];
    end

    assign sda_oe       = oe_q;
    assign scl_oe       = 1'b0;
    assign busy         = (state_q != IDLE);
    assign i2c_wr_valid = wr_vld_q;
    assign i2c_wr_addr  = wr_addr_q;
    assign i2c_wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C controller on a wired-AND bus plus a register/pointer model.
// Latency: n/a. Backpressure: n/a.
// Scenario tasks run in sequence; random transactions are scored against the model.
module tb_i2c_target_regs;

    localparam int NR = 16;
    localparam int Q  = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tb_sda_low = 1'b0;
    logic tb_scl_low = 1'b0;
    logic sda_in, scl_in, sda_oe, scl_oe;
    logic host_wr_en = 1'b0;
    logic [3:0] host_wr_addr = '0;
    logic [7:0] host_wr_data = '0;
    logic [NR*8-1:0] regs_flat;
    logic i2c_wr_valid;
    logic [3:0] i2c_wr_addr;
    logic [7:0] i2c_wr_data;
    logic busy;

    int n_checks = 0;
    int n_err = 0;
    logic [7:0]  mregs [NR];
    logic [3:0]  mptr;
    logic [11:0] wr_log [$];
    logic [11:0] exp_log [$];
    bit oe_seen;

    assign scl_in = ~tb_scl_low;
    assign sda_in = ~(tb_sda_low | sda_oe);

    always #10 clk = ~clk;

    i2c_target_regs #(.DEV_ADDR(7'h42), .NUM_REGS(NR), .FILTER_LEN(4)) dut (
        .clk(clk), .reset_n(reset_n), .sda_in(sda_in), .scl_in(scl_in),
        .sda_oe(sda_oe), .scl_oe(scl_oe),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .regs_flat(regs_flat), .i2c_wr_valid(i2c_wr_valid), .i2c_wr_addr(i2c_wr_addr),
        .i2c_wr_data(i2c_wr_data), .busy(busy)
    );

    always @(negedge clk) begin
        if (i2c_wr_valid) wr_log.push_back({i2c_wr_addr, i2c_wr_data});
        if (sda_oe) oe_seen = 1'b1;
    end

    function automatic logic [NR*8-1:0] model_flat();
        logic [NR*8-1:0] v;
        for (int i = 0; i < NR; i++) v[i*8 +: 8] = mregs[i];
        return v;
    endfunction

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic clock_bit(input logic drive_low, input bit glitch, output logic smp);
        tb_sda_low = drive_low;
        if (glitch) begin
            repeat (3) @(negedge clk);
            tb_scl_low = 1'b0;
            repeat (2) @(negedge clk);
            tb_scl_low = 1'b1;
            repeat (Q - 5) @(negedge clk);
        end else begin
            wait_q();
        end
        tb_scl_low = 1'b0;
        wait_q();
        smp = sda_in;
        wait_q();
        tb_scl_low = 1'b1;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, input int gl, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(!b[i], (7 - i) == gl, s);
        clock_bit(1'b0, 1'b0, s);
        ack = !s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b0, 1'b0, s);
            d[i] = s;
        end
        clock_bit(!nack, 1'b0, s);
    endtask

    task automatic bus_start();
        tb_sda_low = 1'b0;
        wait_q();
        tb_scl_low = 1'b0;
        wait_q();
        tb_sda_low = 1'b1;
        wait_q();
        tb_scl_low = 1'b1;
        wait_q();
    endtask

    task automatic bus_stop();
        tb_sda_low = 1'b1;
        wait_q();
        tb_scl_low = 1'b0;
        wait_q();
        tb_sda_low = 1'b0;
        wait_q();
        wait_q();
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        host_wr_en = 1'b1;
        host_wr_addr = a;
        host_wr_data = d;
        @(negedge clk);
        host_wr_en = 1'b0;
        mregs[a] = d;
    endtask

    task automatic test_reset();
        logic ack;
        logic [7:0] d, exp;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sda_oe, scl_oe, i2c_wr_valid, busy} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_outs got %b want 0000", {sda_oe, scl_oe, i2c_wr_valid, busy});
        end
        n_checks++;
        if (regs_flat !== '0) begin n_err++; $display("FAIL reset_regs got %h want 0", regs_flat); end
        reset_n = 1'b1;
        for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
        mptr = 4'd0;
        repeat (5) @(negedge clk);
        host_write(4'd0, 8'h77);
        host_write(4'd1, 8'h99);
        n_checks++;
        if (regs_flat !== model_flat()) begin
            n_err++;
            $display("FAIL host_write_regs got %h want %h", regs_flat, model_flat());
        end
        bus_start();
        write_byte({7'h42, 1'b1}, -1, ack);
        n_checks++;
        if (ack !== 1'b1) begin n_err++; $display("FAIL reset_rd_addr_ack got %b want 1", ack); end
        read_byte(1'b1, d);
        exp = mregs[mptr];
        n_checks++;
        if (d !== exp) begin n_err++; $display("FAIL reset_ptr_read got %h want %h", d, exp); end
        bus_stop();
        n_checks++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_after_stop got %b want 0", busy); end
    endtask

    task automatic test_write_basic();
        logic [3:0] acks;
        logic a0, a1, a2, a3;
        wr_log.delete();
        bus_start();
        write_byte({7'h42, 1'b0}, -1, a0);
        write_byte(8'h03, -1, a1);
        write_byte(8'hA5, -1, a2);
        write_byte(8'h5A, -1, a3);
        bus_stop();
        acks = {a0, a1, a2, a3};
        mptr = 4'd3;
        mregs[mptr] = 8'hA5; mptr++;
        mregs[mptr] = 8'h5A; mptr++;
        n_checks++;
        if (acks !== 4'hF) begin n_err++; $display("FAIL wr_acks got %b want 1111", acks); end
        n_checks++;
        if (regs_flat !== model_flat()) begin
            n_err++;
            $display("FAIL wr_regs got %h want %h", regs_flat, model_flat());
        end
        n_checks++;
        if (wr_log.size() != 2) begin
            n_err++;
            $display("FAIL wr_pulse_count got %0d want 2", wr_log.size());
        end else begin
            n_checks++;
            if (wr_log[0] !== {4'd3, 8'hA5} || wr_log[1] !== {4'd4, 8'h5A}) begin
                n_err++;
                $display("FAIL wr_pulse_vals got %h,%h want 3a5,45a", wr_log[0], wr_log[1]);
            end
        end
    endtask

    task automatic test_read_wrap();
        logic a0, a1, a2;
        logic [7:0] d, exp;
        for (int i = 0; i < NR; i++) host_write(4'(i), 8'(i));
        bus_start();
        write_byte({7'h42, 1'b0}, -1, a0);
        write_byte(8'h0F, -1, a1);
        mptr = 4'hF;
        bus_start();
        write_byte({7'h42, 1'b1}, -1, a2);
        n_checks++;
        if ({a0, a1, a2} !== 3'b111) begin n_err++; $display("FAIL rd_acks got %b want 111", {a0, a1, a2}); end
        for (int k = 0; k < 3; k++) begin
            read_byte(k == 2, d);
            exp = mregs[mptr];
            n_checks++;
            if (d !== exp) begin n_err++; $display("FAIL rd_wrap_byte%0d got %h want %h", k, d, exp); end
            if (k < 2) mptr++;
        end
        n_checks++;
        if (sda_oe !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rd_after_nack got oe=%b busy=%b want oe=0 busy=1", sda_oe, busy);
        end
        bus_stop();
    endtask

    task automatic test_wrong_addr();
        logic a0, a1, a2;
        oe_seen = 1'b0;
        wr_log.delete();
        bus_start();
        write_byte({7'h43, 1'b0}, -1, a0);
        write_byte(8'h00, -1, a1);
        write_byte(8'hFF, -1, a2);
        n_checks++;
        if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL na_acks got %b want 000", {a0, a1, a2}); end
        n_checks++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL na_busy got %b want 1", busy); end
        bus_stop();
        n_checks++;
        if (busy !== 1'b0 || oe_seen !== 1'b0 || wr_log.size() != 0) begin
            n_err++;
            $display("FAIL na_after got busy=%b oe_seen=%b pulses=%0d want 0 0 0", busy, oe_seen, wr_log.size());
        end
        n_checks++;
        if (regs_flat !== model_flat()) begin
            n_err++;
            $display("FAIL na_regs got %h want %h", regs_flat, model_flat());
        end
    endtask

    task automatic test_host_collision();
        logic a0, a1, a2;
        bit hit;
        hit = 1'b0;
        wr_log.delete();
        fork
            begin
                bus_start();
                write_byte({7'h42, 1'b0}, -1, a0);
                write_byte(8'h02, -1, a1);
                write_byte(8'h22, -1, a2);
                bus_stop();
            end
            begin
                for (int c = 0; c < 3000 && !hit; c++) begin
                    @(negedge clk);
                    if (dut.i2c_commit) begin
                        host_wr_en = 1'b1;
                        host_wr_addr = 4'd2;
                        host_wr_data = 8'h11;
                        hit = 1'b1;
                        @(negedge clk);
                        host_wr_en = 1'b0;
                    end
                end
            end
        join
        mregs[2] = 8'h22;
        if (hit) mregs[2] = 8'h11;
        mptr = 4'd3;
        n_checks++;
        if (hit !== 1'b1) begin n_err++; $display("FAIL coll_commit_timeout got 0 want 1"); end
        n_checks++;
        if (regs_flat[2*8 +: 8] !== 8'h11) begin
            n_err++;
            $display("FAIL coll_reg2 got %h want 11", regs_flat[2*8 +: 8]);
        end
        n_checks++;
        if (wr_log.size() != 1 || wr_log[0] !== {4'd2, 8'h22}) begin
            n_err++;
            $display("FAIL coll_pulse got n=%0d v=%h want n=1 v=222", wr_log.size(), wr_log.size() ? wr_log[0] : 12'h0);
        end
    endtask

    task automatic test_glitch();
        logic a0, a1, a2;
        wr_log.delete();
        bus_start();
        write_byte({7'h42, 1'b0}, 2, a0);
        write_byte(8'h07, -1, a1);
        write_byte(8'h3C, 4, a2);
        bus_stop();
        mptr = 4'd7;
        mregs[mptr] = 8'h3C;
        mptr++;
        n_checks++;
        if ({a0, a1, a2} !== 3'b111 || wr_log.size() != 1) begin
            n_err++;
            $display("FAIL glitch_acks got %b pulses=%0d want 111 pulses=1", {a0, a1, a2}, wr_log.size());
        end
        n_checks++;
        if (regs_flat !== model_flat()) begin
            n_err++;
            $display("FAIL glitch_regs got %h want %h", regs_flat, model_flat());
        end
    endtask

    task automatic test_stop_midbyte();
        logic a0, a1, s;
        wr_log.delete();
        bus_start();
        write_byte({7'h42, 1'b0}, -1, a0);
        write_byte(8'h09, -1, a1);
        mptr = 4'd9;
        clock_bit(1'b0, 1'b0, s);
        clock_bit(1'b1, 1'b0, s);
        clock_bit(1'b0, 1'b0, s);
        clock_bit(1'b0, 1'b0, s);
        bus_stop();
        n_checks++;
        if ({a0, a1} !== 2'b11 || wr_log.size() != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL stop_mid got acks=%b pulses=%0d busy=%b want 11 0 0", {a0, a1}, wr_log.size(), busy);
        end
        n_checks++;
        if (regs_flat !== model_flat()) begin
            n_err++;
            $display("FAIL stop_mid_regs got %h want %h", regs_flat, model_flat());
        end
    endtask

    task automatic test_random();
        logic ack;
        logic [7:0] d, p, exp;
        logic [6:0] a7;
        bit good;
        int nb, nr;
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(0, 2)) host_write(4'($urandom_range(0, 15)), 8'($urandom));
            good = ($urandom_range(0, 4) != 0);
            a7 = good ? 7'h42 : 7'($urandom_range(0, 127));
            if (!good && a7 == 7'h42) a7 = 7'h41;
            p = 8'($urandom);
            nb = $urandom_range(0, 3);
            wr_log.delete();
            exp_log.delete();
            bus_start();
            write_byte({a7, 1'b0}, -1, ack);
            n_checks++;
            if (ack !== good) begin n_err++; $display("FAIL rnd%0d_addr_ack got %b want %b", it, ack, good); end
            write_byte(p, -1, ack);
            if (good) mptr = p[3:0];
            for (int b = 0; b < nb; b++) begin
                d = 8'($urandom);
                write_byte(d, -1, ack);
                n_checks++;
                if (ack !== good) begin n_err++; $display("FAIL rnd%0d_data_ack got %b want %b", it, ack, good); end
                if (good) begin
                    mregs[mptr] = d;
                    exp_log.push_back({mptr, d});
                    mptr++;
                end
            end
            bus_start();
            write_byte({7'h42, 1'b1}, -1, ack);
            nr = $urandom_range(1, 3);
            for (int k = 0; k < nr; k++) begin
                read_byte(k == nr - 1, d);
                exp = mregs[mptr];
                n_checks++;
                if (d !== exp) begin n_err++; $display("FAIL rnd%0d_read%0d got %h want %h", it, k, d, exp); end
                if (k < nr - 1) mptr++;
            end
            bus_stop();
            n_checks++;
            if (regs_flat !== model_flat()) begin
                n_err++;
                $display("FAIL rnd%0d_regs got %h want %h", it, regs_flat, model_flat());
            end
            n_checks++;
            if (wr_log.size() != exp_log.size()) begin
                n_err++;
                $display("FAIL rnd%0d_pulses got %0d want %0d", it, wr_log.size(), exp_log.size());
            end else begin
                for (int k = 0; k < exp_log.size(); k++) begin
                    n_checks++;
                    if (wr_log[k] !== exp_log[k]) begin
                        n_err++;
                        $display("FAIL rnd%0d_pulse%0d got %h want %h", it, k, wr_log[k], exp_log[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midread();
        logic a0, a1, a2;
        host_write(4'd5, 8'h00);
        bus_start();
        write_byte({7'h42, 1'b0}, -1, a0);
        write_byte(8'h05, -1, a1);
        bus_start();
        write_byte({7'h42, 1'b1}, -1, a2);
        n_checks++;
        if ({a0, a1, a2} !== 3'b111 || sda_oe !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_setup got acks=%b oe=%b want 111 oe=1", {a0, a1, a2}, sda_oe);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (sda_oe !== 1'b0 || regs_flat !== '0) begin
            n_err++;
            $display("FAIL rst_mid_release got oe=%b regs=%h want oe=0 regs=0", sda_oe, regs_flat);
        end
        tb_sda_low = 1'b0;
        tb_scl_low = 1'b0;
        for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
        mptr = 4'd0;
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || sda_oe !== 1'b0 || regs_flat !== model_flat()) begin
            n_err++;
            $display("FAIL rst_mid_after got busy=%b oe=%b regs=%h want 0 0 0", busy, sda_oe, regs_flat);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_wrap();
        test_wrong_addr();
        test_host_collision();
        test_glitch();
        test_stop_midbyte();
        test_random();
        test_reset_midread();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
